// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-2 demux and its output FIFOs.
// Optional statistics counters are enabled by DEMUX_STATS_EN.
package demux_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 8;

  typedef logic [1:0] fifo_cnt_t;

endpackage

// File: rtl/demux1_2_fifo2.sv
// Two-entry FIFO with 1-bit pointers; the head output keeps
// the last popped word while the FIFO is empty.
module fifo2
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  fifo_cnt_t        cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == fifo_cnt_t'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // when empty, the slot behind rd_ptr is the word popped last
  assign dout = empty ? mem[~rd_ptr] : mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/demux1_2.sv
// 1-to-2 demux routing each input word by SEL into one of two FIFOs.
// DEMUX_STATS_EN adds per-route accepted-word counters CNT_A/CNT_B.
module demux1_2
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SEL,
  input  logic [WIDTH-1:0] IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] A,
  output logic             A_VALID,
  input  logic             A_READY,
  output logic [WIDTH-1:0] B,
  output logic             B_VALID,
  input  logic             B_READY
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] CNT_A,
  output logic [CNT_W-1:0] CNT_B
`endif
);

  logic full_a;
  logic full_b;
  logic empty_a;
  logic empty_b;
  logic xfer;
  logic push_a;
  logic push_b;

  // a full route refuses input even if it pops this cycle
  assign IN_READY = SEL ? !full_b : !full_a;
  assign xfer     = IN_VALID && IN_READY;
  assign push_a   = xfer && !SEL;
  assign push_b   = xfer && SEL;
  assign A_VALID  = !empty_a;
  assign B_VALID  = !empty_b;

  fifo2 #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo_a (
    .CLK  (CLK),
    .RST_N(RST_N),
    .push (push_a),
    .pop  (A_READY),
    .din  (IN),
    .dout (A),
    .full (full_a),
    .empty(empty_a)
  );

  fifo2 #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo_b (
    .CLK  (CLK),
    .RST_N(RST_N),
    .push (push_b),
    .pop  (B_READY),
    .din  (IN),
    .dout (B),
    .full (full_b),
    .empty(empty_b)
  );

`ifdef DEMUX_STATS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CNT_A <= '0;
      CNT_B <= '0;
    end else begin
      if (push_a) CNT_A <= CNT_A + 1'b1;
      if (push_b) CNT_B <= CNT_B + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1_2.sv
// Table-driven and random bench for demux1_2 with a queue scoreboard.
// Counter checks are compiled in when DEMUX_STATS_EN is defined.
module tb_demux1_2;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         SEL = 1'b0;
  logic [W-1:0] IN = '0;
  logic         IN_VALID = 1'b0;
  logic         IN_READY;
  logic [W-1:0] A;
  logic         A_VALID;
  logic         A_READY = 1'b0;
  logic [W-1:0] B;
  logic         B_VALID;
  logic         B_READY = 1'b0;
`ifdef DEMUX_STATS_EN
  logic [7:0]   CNT_A;
  logic [7:0]   CNT_B;
`endif

  demux1_2 #(.WIDTH(W), .DEPTH(2)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .SEL     (SEL),
    .IN      (IN),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .A       (A),
    .A_VALID (A_VALID),
    .A_READY (A_READY),
    .B       (B),
    .B_VALID (B_VALID),
    .B_READY (B_READY)
`ifdef DEMUX_STATS_EN
    ,
    .CNT_A   (CNT_A),
    .CNT_B   (CNT_B)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       sel;
    logic [7:0] din;
    logic       vld;
    logic       ar;
    logic       br;
    logic       rdy;
  } vec_t;

  vec_t       tbl [21];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic [7:0] last_a;
  logic [7:0] last_b;
  logic [7:0] m_cnt_a;
  logic [7:0] m_cnt_b;
  logic       rdy_seen;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    last_a  = '0;
    last_b  = '0;
    m_cnt_a = '0;
    m_cnt_b = '0;
  endtask

  task automatic check_outputs();
    logic [7:0] ea;
    logic [7:0] eb;
    ea = (qa.size() != 0) ? qa[0] : last_a;
    eb = (qb.size() != 0) ? qb[0] : last_b;
    chk("in_ready", 32'(IN_READY),
        32'(SEL ? (qb.size() < 2) : (qa.size() < 2)));
    chk("a_valid", 32'(A_VALID), 32'(qa.size() != 0));
    chk("a_data", 32'(A), 32'(ea));
    chk("b_valid", 32'(B_VALID), 32'(qb.size() != 0));
    chk("b_data", 32'(B), 32'(eb));
`ifdef DEMUX_STATS_EN
    chk("cnt_a", 32'(CNT_A), 32'(m_cnt_a));
    chk("cnt_b", 32'(CNT_B), 32'(m_cnt_b));
`endif
  endtask

  // entered just after a rising edge; returns just after the next one
  task automatic cycle(input logic sel, input logic [7:0] din,
                       input logic vld, input logic ar, input logic br);
    logic rdy;
    SEL = sel;
    IN = din;
    IN_VALID = vld;
    A_READY = ar;
    B_READY = br;
    @(negedge CLK);
    check_outputs();
    rdy_seen = IN_READY;
    rdy = sel ? (qb.size() < 2) : (qa.size() < 2);
    if (qa.size() != 0 && ar) last_a = qa.pop_front();
    if (qb.size() != 0 && br) last_b = qb.pop_front();
    if (vld && rdy) begin
      if (sel) begin
        qb.push_back(din);
        m_cnt_b++;
      end else begin
        qa.push_back(din);
        m_cnt_a++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic async_reset();
    #3 RST_N = 1'b0;
    IN_VALID = 1'b0;
    #1;
    chk("rst_a_valid", 32'(A_VALID), 32'd0);
    chk("rst_b_valid", 32'(B_VALID), 32'd0);
    chk("rst_a_data", 32'(A), 32'd0);
    chk("rst_b_data", 32'(B), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
`ifdef DEMUX_STATS_EN
    chk("rst_cnt_a", 32'(CNT_A), 32'd0);
    chk("rst_cnt_b", 32'(CNT_B), 32'd0);
`endif
    model_clear();
    @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 8'hA3, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};

    model_clear();
    #1;
    chk("init_in_ready", 32'(IN_READY), 32'd1);
    chk("init_a_valid", 32'(A_VALID), 32'd0);
    chk("init_b_valid", 32'(B_VALID), 32'd0);
    chk("init_a_data", 32'(A), 32'd0);
    @(posedge CLK);
    #1 RST_N = 1'b1;

    for (int i = 0; i < 21; i++) begin
      cycle(tbl[i].sel, tbl[i].din, tbl[i].vld, tbl[i].ar, tbl[i].br);
      chk($sformatf("tbl_rdy[%0d]", i), 32'(rdy_seen), 32'(tbl[i].rdy));
    end
    chk("hold_a_last", 32'(A), 32'h0000_00A3);

    cycle(1'b0, 8'hC1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'hC2, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_a_full", 32'(A_VALID), 32'd1);
    async_reset();
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 8'hD1, 1'b1, 1'b1, 1'b1);
    chk("post_rst_push", 32'(A), 32'h0000_00D1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    repeat (300) begin
      cycle(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom));
    end
    repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

`ifdef DEMUX_STATS_EN
    async_reset();
    repeat (257) cycle(1'b0, 8'($urandom), 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("cnt_a_wrap", 32'(CNT_A), 32'd1);
    chk("cnt_b_zero", 32'(CNT_B), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1_2.md
DEMUX1_2 -- requirements
Module: demux1_2

Interface
REQ-001 Parameter: WIDTH, default 8, sets the data width of IN, A and B.
REQ-002 Parameter: DEPTH, default 2, sets the entries per output FIFO; only the value 2 is supported.
REQ-003 Port: CLK  input  1  single clock; all state is updated on the rising edge.
REQ-004 Port: RST_N  input  1  reset, asynchronous assert and active-low.
REQ-005 Port: SEL  input  1  route select, sampled with IN_VALID; 0 routes to A, 1 routes to B.
REQ-006 Port: IN  input  WIDTH  input data word.
REQ-007 Port: IN_VALID  input  1  input word present.
REQ-008 Port: IN_READY  output  1  the selected output FIFO can accept a word.
REQ-009 Port: A  output  WIDTH  head word of the A FIFO.
REQ-010 Port: A_VALID  output  1  the A FIFO is non-empty.
REQ-011 Port: A_READY  input  1  the downstream sink on A consumes the head word.
REQ-012 Port: B, B_VALID, B_READY  same widths and meanings as A, A_VALID, A_READY, applied to output B.
REQ-013 Port: CNT_A  output  8  words accepted toward A; present only when DEMUX_STATS_EN is defined.
REQ-014 Port: CNT_B  output  8  words accepted toward B; present only when DEMUX_STATS_EN is defined.

Function
REQ-015 IN_READY SHALL be combinational: (SEL==0 ? !fullA : !fullB); it SHALL NOT depend on IN_VALID.
REQ-016 An input transfer SHALL occur on a rising CLK edge where IN_VALID & IN_READY; IN SHALL then be pushed into the FIFO chosen by SEL.
REQ-017 Routing SHALL be decided per word from SEL at the transfer edge; SEL may change every cycle.
REQ-018 An output pop SHALL occur on an edge where X_VALID & X_READY; A pops and B pops are independent and may coincide.
REQ-019 Latency SHALL be 1 cycle: a word accepted at edge n SHALL appear on A/B with VALID high after edge n when that FIFO was empty.
REQ-020 Order within each output SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-021 Each FIFO SHALL use 1-bit read/write pointers plus a 2-bit count; the pointers SHALL wrap 1->0.
REQ-022 Full FIFO: IN_READY SHALL be 0 for that route even if a pop occurs in the same cycle; no same-cycle push-on-pop when full.
REQ-023 Empty FIFO: X_VALID SHALL be 0, X SHALL hold its last value, and X_READY SHALL be ignored.
REQ-024 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-025 A push and a pop to different FIFOs in the same cycle SHALL each take effect.
REQ-026 A_VALID/A SHALL remain stable while A_VALID & !A_READY; the same rule SHALL hold for B.

Reset
REQ-027 When RST_N goes low, all state SHALL clear immediately, independent of CLK: counts=0, pointers=0, A_VALID=B_VALID=0, A=B=0, CNT_A=CNT_B=0.
REQ-028 During reset, IN_READY SHALL be 1, because both FIFOs are empty.
REQ-029 Reset asserted mid-operation SHALL discard buffered words; no output SHALL be asserted after release until a new push.
REQ-030 The first transfer SHALL be possible on the first rising edge after RST_N deasserts.

Configuration
REQ-031 Macro DEMUX_STATS_EN: when it is defined, CNT_A/CNT_B SHALL exist and each SHALL increment by 1 per accepted word on its route, wrapping 255->0.
REQ-032 When DEMUX_STATS_EN is undefined, the CNT ports and the counter logic SHALL be absent, and routing behaviour SHALL be identical.

Structure
REQ-033 Shared package demux_pkg SHALL hold: DATA_W_DEF=8, FIFO_DEPTH=2, CNT_W=8, and typedef fifo_cnt_t (2-bit).
REQ-034 One sub-module fifo2 (push/pop/full/empty/data, async active-low reset) SHALL be instantiated twice, once for A and once for B.

Verification
REQ-035 Scenario: reset, then SEL=0, IN=8'h5A, IN_VALID=1 for 1 cycle, A_READY=1 -> A_VALID=1 with A=8'h5A one cycle later; B_VALID stays 0.
REQ-036 Scenario: B_READY=0, push 8'h11, 8'h22 with SEL=1 -> IN_READY=0 for SEL=1 and 1 for SEL=0; then B_READY=1 -> B delivers 8'h11 then 8'h22.
REQ-037 Scenario: alternate SEL 0,1,0,1 with IN=1,2,3,4, both READY=1 -> A outputs 1,3 and B outputs 2,4, in order.
REQ-038 Scenario: A FIFO holds 1 word, push and pop A in the same cycle -> count stays 1 and A advances to the new word.
REQ-039 Scenario: fill A, drop RST_N mid-cycle -> A_VALID=0 asynchronously, and after release A_VALID stays 0 until a new push.
REQ-040 Scenario: with DEMUX_STATS_EN, push 257 words to A -> CNT_A=1 and CNT_B=0.
